// File: rtl/exe_div_ctrl_if.sv
// Request/result handshake bundle between the EXE issue logic and the iterative divider.
interface exe_div_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic [4:0]  req_dest;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_dest;

   modport master (
      output req_valid, req_op, req_src1, req_src2, req_dest, res_ready,
      input  req_ready, res_valid, res_data, res_dest
   );

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, req_dest, res_ready,
      output req_ready, res_valid, res_data, res_dest
   );
endinterface

// File: rtl/exe_div_ctrl.sv
// Iterative radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu with
// sign fix-up, result hold, in-flight destination export and flush abort.
module exe_div_ctrl (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   exe_div_ctrl_if.slave   div_if,
   output logic            busy,
   output logic [4:0]      busy_dest
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [4:0]  dest_q, dest_d;
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] res_data_q, res_data_d;

   logic        op_onehot;
   logic        is_signed;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         op_q       <= '0;
         dest_q     <= '0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dest_q     <= dest_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dest_d     = dest_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      res_data_d = res_data_q;

      op_onehot = (div_if.req_op != '0) && ((div_if.req_op & (div_if.req_op - 4'd1)) == '0);
      is_signed = div_if.req_op[3] | div_if.req_op[2];

      // rem < divisor holds between steps, so bit 32 of the shifted value is
      // always clear and the 33-bit difference's sign bit decides the step.
      shifted = {rem_q, dvd_q[31]};
      diff    = shifted - {1'b0, dvs_q};

      q_fix = (s1_q ^ s2_q) ? (~dvd_q + 32'd1) : dvd_q;
      r_fix = s1_q ? (~rem_q + 32'd1) : rem_q;

      unique case (state_q)
         IDLE: begin
            if (div_if.req_valid && op_onehot && !flush) begin
               op_d   = div_if.req_op;
               dest_d = div_if.req_dest;
               s1_d   = is_signed & div_if.req_src1[31];
               s2_d   = is_signed & div_if.req_src2[31];
               dvd_d  = (is_signed & div_if.req_src1[31]) ? (~div_if.req_src1 + 32'd1) : div_if.req_src1;
               dvs_d  = (is_signed & div_if.req_src2[31]) ? (~div_if.req_src2 + 32'd1) : div_if.req_src2;
               rem_d  = '0;
               cnt_d  = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = diff[32] ? shifted[31:0] : diff[31:0];
            dvd_d = {dvd_q[30:0], ~diff[32]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            res_data_d = (op_q[3] | op_q[1]) ? q_fix : r_fix;
            state_d    = DONE;
         end
         DONE: begin
            if (div_if.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) state_d = IDLE;
   end

   assign div_if.req_ready = (state_q == IDLE);
   assign div_if.res_valid = (state_q == DONE);
   assign div_if.res_data  = res_data_q;
   assign div_if.res_dest  = dest_q;
   assign busy             = (state_q != IDLE);
   assign busy_dest        = (state_q != IDLE) ? dest_q : '0;
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl: vector table plus flush, hold, reset sequences.
module tb_exe_div_ctrl;
   localparam logic [3:0] DIV_W  = 4'b1000;
   localparam logic [3:0] MOD_W  = 4'b0100;
   localparam logic [3:0] DIV_WU = 4'b0010;
   localparam logic [3:0] MOD_WU = 4'b0001;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  dest;
   } exp_t;

   logic clk;
   logic resetn;
   logic flush;
   logic busy;
   logic [4:0] busy_dest;

   exe_div_ctrl_if dif();

   exe_div_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .div_if    (dif),
      .busy      (busy),
      .busy_dest (busy_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t exp_q[$];
   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input bit push);
      int unsigned guard;
      exp_t e;
      guard = 0;
      while (!dif.req_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) chk("ready_timeout", 32'd1, 32'd0);
      dif.req_valid = 1'b1;
      dif.req_op    = op;
      dif.req_src1  = a;
      dif.req_src2  = b;
      dif.req_dest  = d;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      if (push) begin
         e.data = exp;
         e.dest = d;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_valid(output int unsigned cycles);
      cycles = 0;
      while (!dif.res_valid && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (!dif.res_valid) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic collect(input string name);
      int unsigned cycles;
      exp_t e;
      wait_valid(cycles);
      chk({name, "_latency"}, cycles, 32'd33);
      if (exp_q.size() == 0) begin
         chk({name, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_data"}, dif.res_data, e.data);
         chk({name, "_dest"}, {27'd0, dif.res_dest}, {27'd0, e.dest});
      end
      dif.res_ready = 1'b1;
      @(posedge clk); #1;
      dif.res_ready = 1'b0;
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int unsigned cycles;
      logic [31:0] held;
      exp_t e;

      vt[0]  = '{DIV_W,  32'd7,          32'hFFFFFFFE, 5'd5,  32'hFFFFFFFD};
      vt[1]  = '{MOD_W,  32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF};
      vt[2]  = '{MOD_WU, 32'hFFFFFFF9,   32'd2,        5'd7,  32'h00000001};
      vt[3]  = '{DIV_WU, 32'hFFFFFFFF,   32'h10,       5'd8,  32'h0FFFFFFF};
      vt[4]  = '{DIV_W,  32'h80000000,   32'hFFFFFFFF, 5'd9,  32'h80000000};
      vt[5]  = '{MOD_W,  32'h80000000,   32'hFFFFFFFF, 5'd10, 32'h00000000};
      vt[6]  = '{DIV_WU, 32'h1234,       32'd0,        5'd11, 32'hFFFFFFFF};
      vt[7]  = '{DIV_W,  32'h80000000,   32'd0,        5'd12, 32'h00000001};
      vt[8]  = '{MOD_W,  32'h1234,       32'd0,        5'd13, 32'h00001234};
      vt[9]  = '{DIV_W,  32'hFFFFFF9C,   32'd7,        5'd14, 32'hFFFFFFF2};
      vt[10] = '{MOD_W,  32'hFFFFFF9C,   32'd7,        5'd15, 32'hFFFFFFFE};
      vt[11] = '{DIV_WU, 32'd100,        32'd7,        5'd16, 32'd14};
      vt[12] = '{MOD_WU, 32'hFFFFFFFF,   32'h10000,    5'd31, 32'h0000FFFF};
      vt[13] = '{DIV_W,  32'hFFFFFFF8,   32'hFFFFFFFE, 5'd1,  32'd4};

      resetn = 1'b0;
      flush  = 1'b0;
      dif.req_valid = 1'b0;
      dif.req_op    = '0;
      dif.req_src1  = '0;
      dif.req_src2  = '0;
      dif.req_dest  = '0;
      dif.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, dif.req_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, dif.res_valid}, 32'd0);
      chk("rst_res_data",  dif.res_data, 32'd0);
      chk("rst_res_dest",  {27'd0, dif.res_dest}, 32'd0);
      chk("rst_busy",      {31'd0, busy}, 32'd0);
      chk("rst_busy_dest", {27'd0, busy_dest}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].exp, 1'b1);
         chk($sformatf("vec%0d_busy_dest", i), {27'd0, busy_dest}, {27'd0, vt[i].d});
         collect($sformatf("vec%0d", i));
      end

      // Non-one-hot op must be ignored.
      dif.req_valid = 1'b1;
      dif.req_op    = 4'b0011;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      chk("bad_op_busy", {31'd0, busy}, 32'd0);

      // Flush after ten CALC steps.
      issue(DIV_WU, 32'd1000, 32'd3, 5'd9, 32'd0, 1'b0);
      chk("flush_busy_dest_pre", {27'd0, busy_dest}, 32'd9);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy",      {31'd0, busy}, 32'd0);
      chk("flush_busy_dest", {27'd0, busy_dest}, 32'd0);
      chk("flush_res_valid", {31'd0, dif.res_valid}, 32'd0);
      chk("flush_req_ready", {31'd0, dif.req_ready}, 32'd1);
      issue(DIV_WU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
      collect("post_flush");

      // Hold result with res_ready low, then check no accept in the DONE cycle.
      issue(DIV_W, 32'hFFFFFF9C, 32'd7, 5'd12, 32'hFFFFFFF2, 1'b1);
      wait_valid(cycles);
      chk("hold_latency", cycles, 32'd33);
      held = dif.res_data;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, dif.res_valid}, 32'd1);
         chk("hold_data",  dif.res_data, held);
         chk("hold_req_ready", {31'd0, dif.req_ready}, 32'd0);
      end
      e = exp_q.pop_front();
      chk("hold_exp_data", dif.res_data, e.data);
      chk("hold_exp_dest", {27'd0, dif.res_dest}, {27'd0, e.dest});
      dif.req_valid = 1'b1;
      dif.req_op    = MOD_WU;
      dif.req_src1  = 32'd100;
      dif.req_src2  = 32'd7;
      dif.req_dest  = 5'd20;
      dif.res_ready = 1'b1;
      @(posedge clk); #1;
      dif.res_ready = 1'b0;
      chk("release_busy",      {31'd0, busy}, 32'd0);
      chk("release_res_valid", {31'd0, dif.res_valid}, 32'd0);
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      chk("next_accept_busy", {31'd0, busy}, 32'd1);
      e.data = 32'd2;
      e.dest = 5'd20;
      exp_q.push_back(e);
      collect("after_hold");

      // Reset in the middle of CALC.
      issue(DIV_WU, 32'd5000, 32'd9, 5'd7, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("mrst_req_ready", {31'd0, dif.req_ready}, 32'd1);
      chk("mrst_res_valid", {31'd0, dif.res_valid}, 32'd0);
      chk("mrst_res_data",  dif.res_data, 32'd0);
      chk("mrst_res_dest",  {27'd0, dif.res_dest}, 32'd0);
      chk("mrst_busy",      {31'd0, busy}, 32'd0);
      chk("mrst_busy_dest", {27'd0, busy_dest}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;
      issue(MOD_W, 32'd7, 32'hFFFFFFFE, 5'd4, 32'd1, 1'b1);
      collect("post_reset");

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
